auth_access_controller: RTL and testbench



---
 rtl/auth_access_controller.sv | 165 ++++++++++++++++
 tb/tb_auth_access_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/auth_access_controller.sv
// Grant/deny sequencer behind the authentication comparator: failed-attempt counting and timed lockout.
// Optional FAIL_COUNT_EN adds a saturating FAIL_TOTAL counter of all failed attempts.
module auth_access_controller #(
  parameter int unsigned MAX_ATTEMPTS = 3,
  parameter int unsigned GRANT_CYCLES = 100,
  parameter int unsigned LOCK_CYCLES  = 1000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CODE_VALID,
  input  logic       AUT1,
  input  logic       AUT2,
  input  logic       AUT3,
  output logic       GRANT,
  output logic [1:0] LEVEL,
  output logic       DENY,
  output logic       LOCKED,
  output logic [3:0] ATTEMPTS_LEFT
`ifdef FAIL_COUNT_EN
  ,
  output logic [7:0] FAIL_TOTAL
`endif
);

  localparam int unsigned MaxCycles = (GRANT_CYCLES > LOCK_CYCLES) ? GRANT_CYCLES : LOCK_CYCLES;
  localparam int unsigned TimerW    = $clog2(MaxCycles + 1);

  localparam logic [TimerW-1:0] GrantLoad   = TimerW'(GRANT_CYCLES - 1);
  localparam logic [TimerW-1:0] LockLoad    = TimerW'(LOCK_CYCLES - 1);
  localparam logic [3:0]        AttemptsMax = 4'(MAX_ATTEMPTS);

  typedef enum logic [1:0] {StIdle, StGranted, StDenied, StLockout} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        attempts_q, attempts_d;
  logic [1:0]        level_q, level_d;
  logic              grant_q, grant_d;
  logic              deny_q, deny_d;
  logic              locked_q, locked_d;
  logic              any_aut;
  logic [1:0]        aut_level;
  logic              attempt_fail;

  assign any_aut      = AUT1 | AUT2 | AUT3;
  assign attempt_fail = (state_q == StIdle) && CODE_VALID && !any_aut;

  always_comb begin
    aut_level = 2'd1;
    if (AUT3) begin
      aut_level = 2'd3;
    end else if (AUT2) begin
      aut_level = 2'd2;
    end
  end

  // State register; the output flops sit here too so every output is a flop.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      attempts_q <= AttemptsMax;
      level_q    <= 2'd0;
      grant_q    <= 1'b0;
      deny_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      attempts_q <= attempts_d;
      level_q    <= level_d;
      grant_q    <= grant_d;
      deny_q     <= deny_d;
      locked_q   <= locked_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    attempts_d = attempts_q;
    level_d    = level_q;
    unique case (state_q)
      StIdle: begin
        if (CODE_VALID) begin
          if (any_aut) begin
            state_d    = StGranted;
            level_d    = aut_level;
            attempts_d = AttemptsMax;
            timer_d    = GrantLoad;
          end else begin
            state_d = StDenied;
            if (attempts_q != 4'd0) begin
              attempts_d = attempts_q - 4'd1;
            end
          end
        end
      end
      StGranted: begin
        if (timer_q == '0) begin
          state_d = StIdle;
          level_d = 2'd0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StDenied: begin
        if (attempts_q == 4'd0) begin
          state_d = StLockout;
          timer_d = LockLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StLockout: begin
        if (timer_q == '0) begin
          state_d    = StIdle;
          attempts_d = AttemptsMax;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are precomputed from the next state and registered alongside it.
  always_comb begin
    grant_d  = (state_d == StGranted);
    deny_d   = (state_d == StDenied);
    locked_d = (state_d == StLockout);
  end

  assign GRANT         = grant_q;
  assign LEVEL         = level_q;
  assign DENY          = deny_q;
  assign LOCKED        = locked_q;
  assign ATTEMPTS_LEFT = attempts_q;

`ifdef FAIL_COUNT_EN
  logic [7:0] fail_total_q, fail_total_d;

  always_comb begin
    fail_total_d = fail_total_q;
    if (attempt_fail && (fail_total_q != 8'hFF)) begin
      fail_total_d = fail_total_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      fail_total_q <= 8'd0;
    end else begin
      fail_total_q <= fail_total_d;
    end
  end

  assign FAIL_TOTAL = fail_total_q;
`else
  // No failure history is kept; attempt_fail only feeds the optional counter.
  logic unused_attempt_fail;
  assign unused_attempt_fail = attempt_fail;
`endif

endmodule

// File: tb/tb_auth_access_controller.sv
// Randomized and directed bench for auth_access_controller against a cycle-count reference model.
module tb_auth_access_controller;

  localparam int unsigned MA = 3;
  localparam int unsigned GC = 4;
  localparam int unsigned LC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cv = 1'b0;
  logic       a1 = 1'b0;
  logic       a2 = 1'b0;
  logic       a3 = 1'b0;
  logic       grant;
  logic [1:0] level;
  logic       deny;
  logic       locked;
  logic [3:0] att_left;
`ifdef FAIL_COUNT_EN
  logic [7:0] fail_total;
`endif

  always #5 clk = ~clk;

  auth_access_controller #(
    .MAX_ATTEMPTS (MA),
    .GRANT_CYCLES (GC),
    .LOCK_CYCLES  (LC)
  ) dut (
    .CLK           (clk),
    .RST_N         (rst_n),
    .CODE_VALID    (cv),
    .AUT1          (a1),
    .AUT2          (a2),
    .AUT3          (a3),
    .GRANT         (grant),
    .LEVEL         (level),
    .DENY          (deny),
    .LOCKED        (locked),
    .ATTEMPTS_LEFT (att_left)
`ifdef FAIL_COUNT_EN
    ,
    .FAIL_TOTAL    (fail_total)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Reference model: remaining cycles of each window, as plain counts.
  int m_grant_rem = 0;
  int m_lock_rem  = 0;
  int m_deny      = 0;
  int m_att       = MA;
  int m_level     = 0;
  int m_fail      = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_grant_rem = 0; m_lock_rem = 0; m_deny = 0;
      m_att = MA; m_level = 0; m_fail = 0;
    end else if (m_grant_rem > 0) begin
      m_grant_rem--;
      if (m_grant_rem == 0) m_level = 0;
    end else if (m_deny != 0) begin
      m_deny = 0;
      if (m_att == 0) m_lock_rem = LC;
    end else if (m_lock_rem > 0) begin
      m_lock_rem--;
      if (m_lock_rem == 0) m_att = MA;
    end else if (cv) begin
      if (a1 || a2 || a3) begin
        m_grant_rem = GC;
        m_level = a3 ? 3 : (a2 ? 2 : 1);
        m_att = MA;
      end else begin
        m_deny = 1;
        m_att--;
        if (m_fail < 255) m_fail++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("GRANT", grant, (m_grant_rem > 0) ? 1 : 0);
      check("LEVEL", level, m_level);
      check("DENY", deny, m_deny);
      check("LOCKED", locked, (m_lock_rem > 0) ? 1 : 0);
      check("ATTEMPTS_LEFT", att_left, m_att);
`ifdef FAIL_COUNT_EN
      check("FAIL_TOTAL", fail_total, m_fail);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit x1, input bit x2, input bit x3);
    cv = v; a1 = x1; a2 = x2; a3 = x3;
  endtask

  task automatic attempt(input bit x1, input bit x2, input bit x3);
    drive(1'b1, x1, x2, x3);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    int nd;

    // Reset state
    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    check("lit_reset_grant", grant, 0);
    check("lit_reset_locked", locked, 0);
    check("lit_reset_att", att_left, 3);
    rst_n = 1'b1;
    tick();

    // AUT2 grant: 4-cycle window at level 2
    attempt(1'b0, 1'b1, 1'b0);
    check("lit_lvl2", level, 2);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (grant) n++;
      tick();
    end
    check("lit_grant_len", n, 4);

    // AUT1+AUT3 gives level 3; pulse inside window is ignored
    attempt(1'b1, 1'b0, 1'b1);
    check("lit_lvl3", level, 3);
    n = 0; nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (grant) n++;
      if (deny) nd++;
      drive(i == 1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("lit_grant_len_pulse", n, 4);
    check("lit_no_deny_in_grant", nd, 0);

    // Two fails then AUT1 grant reloads attempts
    attempt(1'b0, 1'b0, 1'b0);
    check("lit_deny1", deny, 1);
    check("lit_att2", att_left, 2);
    tick();
    attempt(1'b0, 1'b0, 1'b0);
    check("lit_att1", att_left, 1);
    tick();
    attempt(1'b1, 1'b0, 1'b0);
    check("lit_grant_lvl1", level, 1);
    check("lit_att_reload", att_left, 3);
    repeat (6) tick();

    // Three fails -> 8-cycle lockout, valid codes ignored
    for (int k = 0; k < 3; k++) begin
      attempt(1'b0, 1'b0, 1'b0);
      if (k < 2) tick();
    end
    check("lit_deny3", deny, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      if (locked) begin
        n++;
        check("lit_att0_lock", att_left, 0);
      end else begin
        break;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("lit_lock_len", n, 8);
    check("lit_post_lock_att", att_left, 3);
    check("lit_post_lock_grant", grant, 0);
    tick();

    // Reset in lockout cycle 3, then immediate grant
    for (int k = 0; k < 3; k++) begin
      attempt(1'b0, 1'b0, 1'b0);
      if (k < 2) tick();
    end
    repeat (3) tick();
    check("lit_lock_c3", locked, 1);
    rst_n = 1'b0;
    tick();
    check("lit_rst_unlock", locked, 0);
    check("lit_rst_att", att_left, 3);
    rst_n = 1'b1;
    attempt(1'b1, 1'b0, 1'b0);
    check("lit_grant_after_rst", grant, 1);
    repeat (6) tick();

    // Randomized traffic
    repeat (3000) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3);
      tick();
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) tick();

`ifdef FAIL_COUNT_EN
    // Saturation of the failure counter across lockouts
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    nd = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (1500) begin
      tick();
      if (deny) nd++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("lit_300_fails", (nd >= 300) ? 1 : 0, 1);
    check("lit_fail_sat", fail_total, 255);
    rst_n = 1'b0;
    tick();
    check("lit_fail_clr", fail_total, 0);
    rst_n = 1'b1;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
